coprocessor_controller: RTL and testbench
=========================================

Name: coprocessor_controller

Overview:
Sequencer in front of the combinational matrix coprocessor (convolution op 3'b111, 5x5 packed 8-bit operands).
- Accepts one command per job, then serially loads matrix A (pixels) and matrix B (kernel) one byte per handshake into 200-bit registers.
- Holds the coprocessor inputs stable for a settle window, captures the 200-bit result and done flag, then streams the n*n result bytes out.
- Sits between the HPS-facing bus bridge and the coprocessor datapath.

Parameters:
ELEM_W, 8, bits per matrix element
MAX_DIM, 5, maximum matrix dimension; packed bus width = MAX_DIM*MAX_DIM*ELEM_W = 200
EXEC_CYCLES, 2, cycles coprocessor inputs are held stable before result capture (min 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept command (IDLE only)
cmd_op  in  3  operation code
cmd_size  in  2  00=2x2, 01=3x3, 10=4x4, 11=5x5
in_valid  in  1  operand byte present
in_ready  out  1  controller accepts operand byte
in_data  in  8  operand byte, row-major, A first then B
out_valid  out  1  result byte present
out_ready  in  1  consumer accepts result byte
out_data  out  8  result byte, row-major
out_last  out  1  marks final result byte of job
busy  out  1  high in every state except IDLE
error  out  1  one-cycle pulse on rejected/failed job
cp_op_code  out  3  to coprocessor op_code
cp_matrix_size  out  2  to coprocessor matrix_size
cp_matrix_a  out  200  to coprocessor matrix_a
cp_matrix_b  out  200  to coprocessor matrix_b
cp_process_done  in  1  from coprocessor process_Done
cp_result  in  200  from coprocessor result_final

Behaviour:
- Reset (any state, mid-job included):
  - State goes to IDLE; A, B and result registers clear to 0; op/size registers clear to 0.
  - All outputs 0 except cmd_ready=1.
  - Partial loads and streams are discarded.
- Element packing: element (r,c) occupies index i=r*5+c, bits [8*i+7 : 8*i]. Positions outside the n x n region are 0. n = cmd_size+2.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch op and size, clear A/B to 0, clear row/col counters, go to LOAD_A.
  - LOAD_A: in_ready=1. Each in_valid&in_ready writes in_data to A at (r,c), then advances c. When c=n-1, c wraps to 0 and r increments. After n*n bytes, reset r/c and go to LOAD_B.
  - LOAD_B: same as LOAD_A, writing into B. After the last byte, go to EXEC with the exec counter at 0.
  - EXEC: cp_* driven from registers. cp_* are driven continuously in all states, but are only meaningful here. After EXEC_CYCLES cycles, go to CAPTURE.
  - CAPTURE (1 cycle): register cp_result and cp_process_done.
    - If done=0, pulse error and go to IDLE (no output stream).
    - Otherwise reset r/c and go to STREAM.
  - STREAM: out_valid=1 and out_data = result at (r,c). Advance only on out_valid&out_ready; out_data/out_last must stay stable while stalled. out_last=1 when r=c=n-1. The handshake on the last byte returns to IDLE.
- Latency, last B byte to first out_valid: EXEC_CYCLES+2 cycles (2x2 job with EXEC_CYCLES=2 gives 4 cycles).
- Command arriving while busy is not accepted (cmd_ready=0); the source holds it.
- in_valid outside LOAD states is ignored; no write occurs.
- No zero-length job exists; minimum is 4 bytes per matrix.

Optional Feature:
OPCODE_CHECK_EN
- Defined: in IDLE, a command with cmd_op != 3'b111 is consumed (cmd_ready handshake). It produces an error pulse in the next cycle and stays in IDLE; no bytes are loaded.
- Undefined: every op runs the full sequence. Unsupported ops fail only through the CAPTURE done=0 path, after operands are loaded.

Decomposition:
- Shared package: state encoding constants (IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, STREAM), OP_CONV=3'b111, size-code constants, ELEM_W/MAX_DIM defaults.
- One natural sub-module: matrix_index_counter, the row/col counter with n-bounded wrap and last flag. It is shared by the load and stream phases.

Test Plan:
- 2x2 job, op 111; A bytes 1,2,3,4; B bytes 1,0,0,1. Expect A bus bytes at idx 0,1,5,6 = 1,2,3,4 and others 0. Expect 4 out bytes matching cp_result idx 0,1,5,6, with out_last on the 4th only.
- 5x5 job with out_ready toggled 1/0 every cycle: 25 bytes out, each held stable while stalled, out_last on byte 25, then cmd_ready=1.
- cmd_op=000 with coprocessor done=0. Without macro: full load, then error pulse after CAPTURE, no out_valid. With OPCODE_CHECK_EN: error 1 cycle after the cmd handshake, in_ready never asserted.
- reset asserted after 3 of 9 A bytes (3x3): next cycle state IDLE, cmd_ready=1, cp_matrix_a=0. A new 2x2 job then completes normally.
- cmd_valid held high during STREAM: cmd_ready=0 throughout, command accepted on the first IDLE cycle.
- in_valid pulsed during EXEC/STREAM: A/B registers unchanged, result stream unaffected.

Source files
------------

// File: rtl/coprocessor_controller_pkg.sv
// Shared constants for the convolution coprocessor sequencer: state codes, op and size codes,
// operand geometry, and the size-code to dimension helper.
package coprocessor_controller_pkg;

    localparam int ELEM_W  = 8;
    localparam int MAX_DIM = 5;
    localparam int BUS_W   = MAX_DIM * MAX_DIM * ELEM_W;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_A  = 3'd1;
    localparam logic [2:0] ST_LOAD_B  = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_STREAM  = 3'd5;

    localparam logic [2:0] OP_CONV = 3'b111;

    localparam logic [1:0] SIZE_2X2 = 2'b00;
    localparam logic [1:0] SIZE_3X3 = 2'b01;
    localparam logic [1:0] SIZE_4X4 = 2'b10;
    localparam logic [1:0] SIZE_5X5 = 2'b11;

    // A size code of 0..3 selects a square matrix of dimension 2..5.
    function automatic logic [2:0] dimFromSize(input logic [1:0] size);
        return 3'd2 + {1'b0, size};
    endfunction

endpackage

// File: rtl/coprocessor_controller_if.sv
// Bus-side handshake bundle of the coprocessor sequencer: command, operand and result
// channels plus status.
interface coprocessor_controller_if;
    import coprocessor_controller_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [1:0]        cmd_size;
    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              error;

    modport master (
        output cmd_valid, cmd_op, cmd_size, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data, out_last, busy, error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_size, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data, out_last, busy, error
    );

endinterface

// File: rtl/coprocessor_controller_index.sv
// Row/column walker over the active n x n region; it produces the packed element index
// and flags the last element. The load and stream phases share it.
module matrix_index_counter
    import coprocessor_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       advance_i,
    input  logic [2:0] dim_i,
    output logic [4:0] index_o,
    output logic       last_o
);

    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic [2:0] lastPos;

    assign lastPos = dim_i - 3'd1;
    assign last_o  = (row_q == lastPos) && (col_q == lastPos);
    assign index_o = 5'(row_q) * 5'(MAX_DIM) + 5'(col_q);

    // Stepping past the last element wraps to (0,0), so the next phase starts clean.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (col_q == lastPos) begin
                col_d = '0;
                row_d = last_o ? 3'd0 : row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/coprocessor_controller.sv
// Sequencer for the combinational convolution coprocessor: command, serial A/B load, settle,
// capture and result streaming. Optional macro OPCODE_CHECK_EN rejects non-convolution ops in IDLE.
module coprocessor_controller
    import coprocessor_controller_pkg::*;
#(
    parameter int EXEC_CYCLES = 2
)
(
    input  logic               clk,
    input  logic               reset,
    coprocessor_controller_if.slave bus,
    output logic [2:0]         cp_op_code,
    output logic [1:0]         cp_matrix_size,
    output logic [BUS_W-1:0]   cp_matrix_a,
    output logic [BUS_W-1:0]   cp_matrix_b,
    input  logic               cp_process_done,
    input  logic [BUS_W-1:0]   cp_result
);

    localparam int EXEC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    logic [2:0]        state_q, state_d;
    logic [2:0]        opCode_q, opCode_d;
    logic [1:0]        size_q, size_d;
    logic [BUS_W-1:0]  matrixA_q, matrixA_d;
    logic [BUS_W-1:0]  matrixB_q, matrixB_d;
    logic [BUS_W-1:0]  result_q, result_d;
    logic [EXEC_W-1:0] execCount_q, execCount_d;
    logic              error_q, error_d;

    logic       cmdFire, inFire, outFire;
    logic       idxClear, idxAdvance, idxLast;
    logic [4:0] idx;
    logic [7:0] bitOffset;
    logic       opRejected;

`ifdef OPCODE_CHECK_EN
    assign opRejected = (bus.cmd_op != OP_CONV);
`else
    assign opRejected = 1'b0;
`endif

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.in_ready  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign bus.out_valid = (state_q == ST_STREAM);
    assign bus.out_data  = bus.out_valid ? result_q[bitOffset +: ELEM_W] : '0;
    assign bus.out_last  = bus.out_valid && idxLast;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.error     = error_q;

    assign cmdFire   = bus.cmd_valid && bus.cmd_ready;
    assign inFire    = bus.in_valid && bus.in_ready;
    assign outFire   = bus.out_valid && bus.out_ready;
    assign bitOffset = 8'(idx) * 8'(ELEM_W);

    assign idxClear   = cmdFire || (state_q == ST_CAPTURE);
    assign idxAdvance = inFire || outFire;

    assign cp_op_code     = opCode_q;
    assign cp_matrix_size = size_q;
    assign cp_matrix_a    = matrixA_q;
    assign cp_matrix_b    = matrixB_q;

    matrix_index_counter u_index (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (idxClear),
        .advance_i (idxAdvance),
        .dim_i     (dimFromSize(size_q)),
        .index_o   (idx),
        .last_o    (idxLast)
    );

    always_comb begin
        state_d     = state_q;
        opCode_d    = opCode_q;
        size_d      = size_q;
        matrixA_d   = matrixA_q;
        matrixB_d   = matrixB_q;
        result_d    = result_q;
        execCount_d = execCount_q;
        error_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmdFire) begin
                    if (opRejected) begin
                        error_d = 1'b1;
                    end else begin
                        opCode_d  = bus.cmd_op;
                        size_d    = bus.cmd_size;
                        matrixA_d = '0;
                        matrixB_d = '0;
                        state_d   = ST_LOAD_A;
                    end
                end
            end
            ST_LOAD_A: begin
                if (inFire) begin
                    matrixA_d[bitOffset +: ELEM_W] = bus.in_data;
                    if (idxLast) state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (inFire) begin
                    matrixB_d[bitOffset +: ELEM_W] = bus.in_data;
                    if (idxLast) begin
                        state_d     = ST_EXEC;
                        execCount_d = '0;
                    end
                end
            end
            ST_EXEC: begin
                if (execCount_q == EXEC_W'(EXEC_CYCLES - 1)) state_d = ST_CAPTURE;
                else execCount_d = execCount_q + 1'b1;
            end
            // A missing done flag means the coprocessor did not handle this op: drop the job.
            ST_CAPTURE: begin
                result_d = cp_result;
                if (!cp_process_done) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (outFire && idxLast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            opCode_q    <= '0;
            size_q      <= '0;
            matrixA_q   <= '0;
            matrixB_q   <= '0;
            result_q    <= '0;
            execCount_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            opCode_q    <= opCode_d;
            size_q      <= size_d;
            matrixA_q   <= matrixA_d;
            matrixB_q   <= matrixB_d;
            result_q    <= result_d;
            execCount_q <= execCount_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_coprocessor_controller.sv
// Directed and randomized bench for coprocessor_controller; the bench plays the coprocessor
// and predicts bus packing and streamed bytes from row-major element arithmetic.
module tb_coprocessor_controller;
    import coprocessor_controller_pkg::*;

    localparam int EXEC = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   cp_op_code;
    logic [1:0]   cp_matrix_size;
    logic [199:0] cp_matrix_a;
    logic [199:0] cp_matrix_b;
    logic         cp_process_done;
    logic [199:0] cp_result;

    int checks   = 0;
    int failures = 0;

    logic [7:0] aBytes[25];
    logic [7:0] bBytes[25];

    coprocessor_controller_if ifc();

    coprocessor_controller #(.EXEC_CYCLES(EXEC)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (ifc),
        .cp_op_code      (cp_op_code),
        .cp_matrix_size  (cp_matrix_size),
        .cp_matrix_a     (cp_matrix_a),
        .cp_matrix_b     (cp_matrix_b),
        .cp_process_done (cp_process_done),
        .cp_result       (cp_result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Element k of an n x n matrix sits at row k/n, column k%n, i.e. slot (k/n)*5 + k%n of the bus.
    function automatic logic [199:0] packMatrix(input bit useB, input int n);
        logic [199:0] packed_bus;
        int pos;
        packed_bus = '0;
        for (int k = 0; k < n * n; k++) begin
            pos = (k / n) * MAX_DIM + (k % n);
            packed_bus = packed_bus | (200'(useB ? bBytes[k] : aBytes[k]) << (pos * ELEM_W));
        end
        return packed_bus;
    endfunction

    function automatic logic [7:0] resultByte(input logic [199:0] res, input int k, input int n);
        return 8'(res >> (((k / n) * MAX_DIM + (k % n)) * ELEM_W));
    endfunction

    function automatic void randomBytes();
        for (int k = 0; k < 25; k++) begin
            aBytes[k] = 8'($urandom);
            bBytes[k] = 8'($urandom);
        end
    endfunction

    // Starts at a negedge and returns at the negedge after the last B byte handshake.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] sz, input bit cmdAlready, output int n);
        int guard;
        n = int'(sz) + 2;
        if (!cmdAlready) begin
            ifc.cmd_valid = 1'b1;
            ifc.cmd_op    = op;
            ifc.cmd_size  = sz;
            guard = 0;
            while (!ifc.cmd_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            checkOutput("cmd_accept", 200'(ifc.cmd_ready), 200'(1));
            @(negedge clk);
            ifc.cmd_valid = 1'b0;
        end
        for (int k = 0; k < 2 * n * n; k++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = (k < n * n) ? aBytes[k] : bBytes[k - n * n];
            guard = 0;
            while (!ifc.in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            checkOutput("in_ready", 200'(ifc.in_ready), 200'(1));
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic receiveStream(input int n, input bit toggle, input bit cmdBlocked);
        int  k;
        int  guard;
        bit  tog;
        k = 0;
        guard = 0;
        tog = 1'b0;
        while (k < n * n && guard < 500) begin
            if (ifc.out_valid) begin
                checkOutput("out_data", 200'(ifc.out_data), 200'(resultByte(cp_result, k, n)));
                checkOutput("out_last", 200'(ifc.out_last), 200'(k == n * n - 1));
                if (cmdBlocked) checkOutput("cmd_blocked", 200'(ifc.cmd_ready), 200'(0));
                ifc.out_ready = toggle ? tog : 1'b1;
                tog = ~tog;
                if (ifc.out_ready) k++;
            end else begin
                ifc.out_ready = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        ifc.out_ready = 1'b0;
        checkOutput("stream_count", 200'(k), 200'(n * n));
    endtask

    task automatic runJob(input logic [1:0] sz, input bit toggle, input bit junk,
                          input bit holdCmd, input bit cmdAlready);
        int n;
        int lat;
        cp_result = 200'({$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom()});
        cp_process_done = 1'b1;
        applyStimulus(OP_CONV, sz, cmdAlready, n);
        checkOutput("matrix_a", cp_matrix_a, packMatrix(1'b0, n));
        checkOutput("matrix_b", cp_matrix_b, packMatrix(1'b1, n));
        checkOutput("op_code", 200'(cp_op_code), 200'(OP_CONV));
        checkOutput("matrix_size", 200'(cp_matrix_size), 200'(sz));
        if (junk) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = 8'($urandom);
        end
        lat = 1;
        while (!ifc.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 200'(lat), 200'(EXEC + 2));
        if (holdCmd) begin
            ifc.cmd_valid = 1'b1;
            ifc.cmd_op    = OP_CONV;
            ifc.cmd_size  = SIZE_2X2;
        end
        receiveStream(n, toggle, holdCmd);
        if (junk) begin
            ifc.in_valid = 1'b0;
            checkOutput("junk_a", cp_matrix_a, packMatrix(1'b0, n));
            checkOutput("junk_b", cp_matrix_b, packMatrix(1'b1, n));
        end
        checkOutput("end_cmd_ready", 200'(ifc.cmd_ready), 200'(1));
        checkOutput("end_out_valid", 200'(ifc.out_valid), 200'(0));
    endtask

    initial begin
        int n;
        int errCount;
        int firstErr;
        bit sawOut;

        reset = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = '0;
        ifc.cmd_size  = '0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b0;
        cp_process_done = 1'b0;
        cp_result = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_cmd_ready", 200'(ifc.cmd_ready), 200'(1));
        checkOutput("rst_busy", 200'(ifc.busy), 200'(0));
        checkOutput("rst_in_ready", 200'(ifc.in_ready), 200'(0));
        checkOutput("rst_out_valid", 200'(ifc.out_valid), 200'(0));
        checkOutput("rst_error", 200'(ifc.error), 200'(0));
        checkOutput("rst_matrix_a", cp_matrix_a, 200'(0));
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] 2x2 directed job");
        aBytes[0] = 8'd1; aBytes[1] = 8'd2; aBytes[2] = 8'd3; aBytes[3] = 8'd4;
        bBytes[0] = 8'd1; bBytes[1] = 8'd0; bBytes[2] = 8'd0; bBytes[3] = 8'd1;
        runJob(SIZE_2X2, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("a_literal", cp_matrix_a, 200'h04030000000201);
        checkOutput("b_literal", cp_matrix_b, 200'h01000000000001);

        $display("[TB] 5x5 job with stalling consumer");
        randomBytes();
        runJob(SIZE_5X5, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] unsupported opcode");
        randomBytes();
`ifdef OPCODE_CHECK_EN
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = 3'b000;
        ifc.cmd_size  = SIZE_2X2;
        checkOutput("bad_op_ready", 200'(ifc.cmd_ready), 200'(1));
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        checkOutput("bad_op_error", 200'(ifc.error), 200'(1));
        checkOutput("bad_op_busy", 200'(ifc.busy), 200'(0));
        ifc.in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checkOutput("bad_op_in_ready", 200'(ifc.in_ready), 200'(0));
            @(negedge clk);
            if (c == 0) checkOutput("bad_op_pulse_end", 200'(ifc.error), 200'(0));
        end
        ifc.in_valid = 1'b0;
`else
        cp_result = 200'({$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom()});
        cp_process_done = 1'b0;
        applyStimulus(3'b000, SIZE_2X2, 1'b0, n);
        errCount = 0;
        firstErr = 0;
        sawOut = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (ifc.error) begin
                errCount++;
                if (firstErr == 0) firstErr = cyc;
            end
            if (ifc.out_valid) sawOut = 1'b1;
            @(negedge clk);
        end
        checkOutput("fail_err_count", 200'(errCount), 200'(1));
        checkOutput("fail_err_cycle", 200'(firstErr), 200'(EXEC + 2));
        checkOutput("fail_no_stream", 200'(sawOut), 200'(0));
        checkOutput("fail_idle", 200'(ifc.cmd_ready), 200'(1));
`endif

        $display("[TB] reset during 3x3 load");
        randomBytes();
        for (int k = 3; k < 25; k++) aBytes[k] = 8'd0;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = OP_CONV;
        ifc.cmd_size  = SIZE_3X3;
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = aBytes[k];
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        checkOutput("partial_a", cp_matrix_a, packMatrix(1'b0, 3));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_cmd_ready", 200'(ifc.cmd_ready), 200'(1));
        checkOutput("mid_rst_busy", 200'(ifc.busy), 200'(0));
        checkOutput("mid_rst_in_ready", 200'(ifc.in_ready), 200'(0));
        checkOutput("mid_rst_matrix_a", cp_matrix_a, 200'(0));
        checkOutput("mid_rst_size", 200'(cp_matrix_size), 200'(0));
        checkOutput("mid_rst_op", 200'(cp_op_code), 200'(0));
        reset = 1'b0;
        @(negedge clk);
        randomBytes();
        runJob(SIZE_2X2, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] 3x3 job with stray in_valid and held command");
        randomBytes();
        runJob(SIZE_3X3, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        checkOutput("held_cmd_busy", 200'(ifc.busy), 200'(1));
        checkOutput("held_cmd_load", 200'(ifc.in_ready), 200'(1));
        randomBytes();
        runJob(SIZE_2X2, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] 4x4 randomized job");
        randomBytes();
        runJob(SIZE_4X4, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
